// File: rtl/ro_entropy_harvester.sv
// ro_entropy_harvester
//    Ring-oscillator entropy source. N_RINGS odd-length gated inverter rings
//    feed per-ring two-flop synchronisers. The synchronised bits (or test_bits
//    in test mode) are XOR-combined into one source bit. That bit is harvested
//    every SAMPLE_DIV enabled cycles and packed MSB-first into OUT_WIDTH-bit
//    words, which are offered on a valid/ready port. A repetition-count health
//    test watches the harvested bit stream.
//
// Ports
//    clk          system clock
//    rst          synchronous, active-high reset
//    ro_en        enables the rings and harvesting
//    test_mode    1: use test_bits instead of the synchronised ring bits
//    test_bits    deterministic stand-in for the ring outputs (not synchronised)
//    rnd_data     assembled random word
//    rnd_valid    rnd_data is valid
//    rnd_ready    consumer accepts the word
//    overflow     sticky: a completed word was dropped
//    health_fail  sticky: the repetition test tripped
//    ring_raw     unsynchronised ring taps, for observation only

`timescale 1ns/1ps

// Behavioural inverter stage. Its delay sets the ring oscillation period.
module ro_inv_cell #(
   parameter int DELAY = 5
) (
   input  logic a,
   output logic y
);
   assign #(DELAY) y = ~a;
endmodule

// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no word offered, rnd_valid=0
// S_HOLD | word offered on rnd_data, rnd_valid=1, waiting for rnd_ready
module ro_entropy_harvester #(
   parameter int N_RINGS     = 4,
   parameter int BASE_STAGES = 3,
   parameter int INV_DELAY   = 5,
   parameter int OUT_WIDTH   = 8,
   parameter int SAMPLE_DIV  = 16,
   parameter int REP_LIMIT   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ro_en,
   input  logic                 test_mode,
   input  logic [N_RINGS-1:0]   test_bits,
   output logic [OUT_WIDTH-1:0] rnd_data,
   output logic                 rnd_valid,
   input  logic                 rnd_ready,
   output logic                 overflow,
   output logic                 health_fail,
   output logic [N_RINGS-1:0]   ring_raw
);
   localparam int DCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int BCW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam int RCW = $clog2(REP_LIMIT + 1);
   localparam logic [DCW-1:0] DIV_LAST = DCW'(SAMPLE_DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(OUT_WIDTH - 1);
   localparam logic [RCW-1:0] REP_MAX  = RCW'(REP_LIMIT);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t               state;
   logic                 ring_gate;
   logic [N_RINGS-1:0]   sync_q1;
   logic [N_RINGS-1:0]   sync_q2;
   logic [DCW-1:0]       div_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic [OUT_WIDTH-1:0] shreg;
   logic [OUT_WIDTH-1:0] next_word;
   logic [RCW-1:0]       rep_cnt;
   logic [RCW-1:0]       rep_next;
   logic                 prev_bit;
   logic                 src;
   logic                 strobe;
   logic                 word_done;

   // Gate is registered so the rings stop cleanly on the edge after ro_en
   // drops or reset asserts; a stopped ring rests at a static level.
   always_ff @(posedge clk) begin
      ring_gate <= ro_en & ~rst;
   end

   for (genvar i = 0; i < N_RINGS; i++) begin : g_ring
      localparam int STAGES = BASE_STAGES + 2*i;
      logic [STAGES:0] node;

      assign node[0] = node[STAGES] & ring_gate;
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         ro_inv_cell #(.DELAY(INV_DELAY)) u_inv (
            .a (node[k]),
            .y (node[k+1])
         );
      end
      assign ring_raw[i] = node[STAGES];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= ring_raw;
         sync_q2 <= sync_q1;
      end
   end

   always_comb begin
      src = ^(test_mode ? test_bits : sync_q2);
   end

   assign strobe    = ro_en && (div_cnt == DIV_LAST);
   assign word_done = strobe && (bit_cnt == BIT_LAST);

   if (OUT_WIDTH > 1) begin : g_shift
      assign next_word = {shreg[OUT_WIDTH-2:0], src};
   end else begin : g_single
      assign next_word = src;
   end

   // rep_cnt==0 only before the first strobe after reset, so that strobe
   // starts a fresh run of length one.
   always_comb begin
      rep_next = rep_cnt;
      if (rep_cnt == '0 || src != prev_bit)
         rep_next = RCW'(1);
      else if (rep_cnt != REP_MAX)
         rep_next = rep_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         rep_cnt     <= '0;
         prev_bit    <= 1'b0;
         rnd_data    <= '0;
         rnd_valid   <= 1'b0;
         overflow    <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         if (ro_en)
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;

         if (strobe) begin
            shreg    <= next_word;
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            rep_cnt  <= rep_next;
            prev_bit <= src;
            if (rep_next == REP_MAX)
               health_fail <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (word_done) begin
                  rnd_data  <= next_word;
                  rnd_valid <= 1'b1;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (rnd_ready) begin
                  // Back-to-back: a word finishing on the handshake edge
                  // replaces the accepted one with no bubble.
                  if (word_done) begin
                     rnd_data <= next_word;
                  end else begin
                     rnd_valid <= 1'b0;
                     state     <= S_IDLE;
                  end
               end else if (word_done) begin
                  overflow <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ro_entropy_harvester.sv
`timescale 1ns/1ps
module tb_ro_entropy_harvester;
   logic       clk = 1'b0;
   logic       rst;
   logic       ro_en;
   logic       test_mode;
   logic [3:0] test_bits;
   logic [7:0] rnd_data;
   logic       rnd_valid;
   logic       rnd_ready;
   logic       overflow;
   logic       health_fail;
   logic [3:0] ring_raw;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ro_entropy_harvester dut (
      .clk         (clk),
      .rst         (rst),
      .ro_en       (ro_en),
      .test_mode   (test_mode),
      .test_bits   (test_bits),
      .rnd_data    (rnd_data),
      .rnd_valid   (rnd_valid),
      .rnd_ready   (rnd_ready),
      .overflow    (overflow),
      .health_fail (health_fail),
      .ring_raw    (ring_raw)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One harvest period: the strobe lands on the 16th enabled edge.
   task automatic strobe_bits(input logic [3:0] b);
      test_bits = b;
      repeat (16) @(negedge clk);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      ro_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic measure_half(input int idx, output int half);
      logic prev;
      real  t [2];
      int   seen;
      seen = 0;
      half = -1;
      #0.5;
      prev = ring_raw[idx];
      for (int k = 0; k < 400 && seen < 2; k++) begin
         #1;
         if (ring_raw[idx] !== prev) begin
            prev    = ring_raw[idx];
            t[seen] = $realtime;
            seen++;
         end
      end
      if (seen == 2)
         half = int'(t[1] - t[0]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int half;

      rst       = 1'b1;
      ro_en     = 1'b0;
      test_mode = 1'b1;
      test_bits = 4'h0;
      rnd_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("rst_data",   rnd_data,    8'h00);
      chk_eq("rst_valid",  rnd_valid,   1'b0);
      chk_eq("rst_ovf",    overflow,    1'b0);
      chk_eq("rst_health", health_fail, 1'b0);
      rst   = 1'b0;
      ro_en = 1'b1;

      // basic word, latency and acceptance
      for (int j = 0; j < 4; j++) strobe_bits(4'b0001);
      for (int j = 0; j < 3; j++) strobe_bits(4'b0011);
      chk_eq("t1_valid_early", rnd_valid, 1'b0);
      strobe_bits(4'b0011);
      chk_eq("t1_valid", rnd_valid, 1'b1);
      chk_eq("t1_data",  rnd_data,  8'hF0);
      @(negedge clk);
      chk_eq("t1_valid_clr", rnd_valid, 1'b0);

      // held word and overflow
      do_reset();
      ro_en     = 1'b1;
      rnd_ready = 1'b0;
      for (int j = 0; j < 8; j++) strobe_bits((j % 2 == 0) ? 4'b0001 : 4'b0000);
      chk_eq("t2_valid1", rnd_valid, 1'b1);
      chk_eq("t2_data1",  rnd_data,  8'hAA);
      chk_eq("t2_ovf0",   overflow,  1'b0);
      for (int j = 0; j < 8; j++) strobe_bits(4'b0001);
      chk_eq("t2_data_held", rnd_data,  8'hAA);
      chk_eq("t2_valid_held", rnd_valid, 1'b1);
      chk_eq("t2_ovf1",      overflow,  1'b1);
      rnd_ready = 1'b1;
      @(negedge clk);
      chk_eq("t2_accept",    rnd_valid, 1'b0);
      chk_eq("t2_ovf_stick", overflow,  1'b1);

      // reset mid-word
      for (int j = 0; j < 5; j++) strobe_bits(4'b0001);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_eq("t5_data",  rnd_data,    8'h00);
      chk_eq("t5_valid", rnd_valid,   1'b0);
      chk_eq("t5_ovf",   overflow,    1'b0);
      chk_eq("t5_hf",    health_fail, 1'b0);
      strobe_bits(4'b0001);
      strobe_bits(4'b0001);
      for (int j = 0; j < 4; j++) strobe_bits(4'b0000);
      strobe_bits(4'b0001);
      chk_eq("t5_valid_early", rnd_valid, 1'b0);
      strobe_bits(4'b0001);
      chk_eq("t5_valid", rnd_valid, 1'b1);
      chk_eq("t5_data2", rnd_data,  8'hC3);

      // repetition health test
      do_reset();
      ro_en = 1'b1;
      for (int j = 0; j < 31; j++) strobe_bits(4'b0001);
      chk_eq("t3_hf_31", health_fail, 1'b0);
      strobe_bits(4'b0001);
      chk_eq("t3_hf_32", health_fail, 1'b1);
      do_reset();
      chk_eq("t3_hf_rst", health_fail, 1'b0);
      ro_en = 1'b1;
      for (int j = 0; j < 40; j++) strobe_bits((j % 2 == 0) ? 4'b0001 : 4'b0000);
      chk_eq("t3_hf_toggle", health_fail, 1'b0);

      // word completes on the handshake edge
      do_reset();
      ro_en     = 1'b1;
      rnd_ready = 1'b0;
      for (int j = 0; j < 8; j++) strobe_bits((j % 2 == 0) ? 4'b0001 : 4'b0000);
      chk_eq("t4_data1", rnd_data, 8'hAA);
      strobe_bits(4'b0000);
      strobe_bits(4'b0000);
      strobe_bits(4'b0001);
      strobe_bits(4'b0001);
      strobe_bits(4'b0000);
      strobe_bits(4'b0000);
      strobe_bits(4'b0001);
      test_bits = 4'b0001;
      repeat (15) @(negedge clk);
      chk_eq("t4_data_pre", rnd_data, 8'hAA);
      rnd_ready = 1'b1;
      @(negedge clk);
      chk_eq("t4_valid", rnd_valid, 1'b1);
      chk_eq("t4_data2", rnd_data,  8'h33);
      chk_eq("t4_ovf",   overflow,  1'b0);
      @(negedge clk);
      chk_eq("t4_valid_clr", rnd_valid, 1'b0);

      // real rings
      do_reset();
      test_mode = 1'b0;
      ro_en     = 1'b1;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         measure_half(i, half);
         chk_eq($sformatf("t6_half_ring%0d", i), 64'(half), 64'(15 + 10*i));
      end
      @(negedge clk);
      ro_en = 1'b0;
      repeat (30) @(negedge clk);
      chk_eq("t6_static_a", ring_raw, 4'hF);
      repeat (20) @(negedge clk);
      chk_eq("t6_static_b", ring_raw, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
